alu_req_arbiter: RTL and testbench



---
 rtl/alu_req_arbiter_pkg.sv | 40 ++++
 rtl/alu_req_arbiter_rr_pick4.sv | 36 +++
 rtl/alu_req_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_req_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter_pkg
// Shared constants and types for the ALU request arbiter:
//   - ALU opcode encodings (4 bits wide)
//   - requester index assignments on the shared ALU operand bus
//   - lock state encoding for the arbiter FSM
//   - one-hot helper used to form the per-requester ready strobe
// -----------------------------------------------------------------------------
package alu_req_arbiter_pkg;

    localparam int ALU_OP_W = 4;
    localparam int REQ_ID_W = 2;

    // ALU opcodes
    localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 4'h2;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 4'h3;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 4'h4;
    localparam logic [ALU_OP_W-1:0] OP_SLT  = 4'h5;
    localparam logic [ALU_OP_W-1:0] OP_SLTU = 4'h6;
    localparam logic [ALU_OP_W-1:0] OP_CMP  = 4'h7;

    // Requester indices on the operand bus
    localparam logic [REQ_ID_W-1:0] REQ_INT = 2'd0;
    localparam logic [REQ_ID_W-1:0] REQ_AGU = 2'd1;
    localparam logic [REQ_ID_W-1:0] REQ_BR  = 2'd2;
    localparam logic [REQ_ID_W-1:0] REQ_DBG = 2'd3;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // One-hot decode of a requester index.
    function automatic logic [3:0] onehot4(input logic [REQ_ID_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational 4-way round-robin picker. Returns the first asserted valid bit
// searching upward from ptr (modulo 4).
// Ports:
//   valid  [3:0] in  : request valid bits
//   ptr    [1:0] in  : highest-priority index this cycle
//   winner [1:0] out : index of the selected requester (0 when none valid)
//   any          out : at least one valid bit is set
// -----------------------------------------------------------------------------
module rr_pick4 (
    input  logic [3:0] valid,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       any
);

    logic [1:0] idx;

    // NOTE: every output of a combinational block gets a default on entry;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        winner = 2'd0;
        idx    = ptr;
        any    = |valid;
        // Walk from the farthest offset back to ptr so the nearest valid
        // requester is the one written last.
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (valid[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
// Round-robin arbiter plus one-stage issue register sharing one ALU datapath
// among four requesters (integer pipe, AGU, branch compare, debug port).
// Locked sequences keep the grant on one requester until it transfers with
// req_lock low.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid [N_REQ]   : request valid per requester
//   req_lock  [N_REQ]   : keep the grant after this transfer
//   req_a/req_b         : operands, requester i in slice i (WIDTH bits each)
//   req_op              : opcode, requester i in slice i (OP_W bits each)
//   req_ready [N_REQ]   : accept strobe, one-hot or zero
//   grant_sel [ID_W]    : combinational winner index (operand mux select)
//   out_valid/out_ready : issue register handshake toward the ALU
//   out_a/out_b/out_op  : registered operation
//   out_id              : requester index of the held operation
//   locked              : lock currently active
// -----------------------------------------------------------------------------
module alu_req_arbiter #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int OP_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_lock,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*OP_W-1:0]  req_op,
    output logic [N_REQ-1:0]       req_ready,
    output logic [ID_W-1:0]        grant_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_a,
    output logic [WIDTH-1:0]       out_b,
    output logic [OP_W-1:0]        out_op,
    output logic [ID_W-1:0]        out_id,
    output logic                   locked
);

    import alu_req_arbiter_pkg::*;

    lock_state_e      lock_state;
    logic [ID_W-1:0]  lock_owner;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  last_sel;

    logic [ID_W-1:0]  pick_idx;
    logic             pick_any;
    logic [ID_W-1:0]  win;
    logic             win_any;
    logic             can_load;
    logic             xfer;

    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [OP_W-1:0]  sel_op;

    rr_pick4 u_pick (
        .valid  (req_valid),
        .ptr    (rr_ptr),
        .winner (pick_idx),
        .any    (pick_any)
    );

    // Winner selection: while locked only the owner may be granted, even if
    // it has dropped valid for a few cycles.
    always_comb begin
        win     = pick_idx;
        win_any = pick_any;
        if (lock_state == LOCKED) begin
            win     = lock_owner;
            win_any = req_valid[lock_owner];
        end
    end

    // With no valid candidate the select keeps its last value so the operand
    // bus does not toggle needlessly.
    assign grant_sel = win_any ? win : last_sel;

    assign can_load  = !out_valid || out_ready;
    assign xfer      = can_load && win_any;
    assign req_ready = xfer ? onehot4(win) : '0;
    assign locked    = (lock_state == LOCKED);

    // Shared 4:1 operand-bus mux, steered by grant_sel.
    assign sel_a  = req_a [grant_sel*WIDTH +: WIDTH];
    assign sel_b  = req_b [grant_sel*WIDTH +: WIDTH];
    assign sel_op = req_op[grant_sel*OP_W  +: OP_W];

    // NOTE: state registers use non-blocking assignments so every flop in
    // this block samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state <= UNLOCKED;
            lock_owner <= '0;
            rr_ptr     <= '0;
            last_sel   <= '0;
            out_valid  <= 1'b0;
            out_a      <= '0;
            out_b      <= '0;
            out_op     <= '0;
            out_id     <= '0;
        end else begin
            last_sel <= grant_sel;
            if (xfer) begin
                out_valid <= 1'b1;
                out_a     <= sel_a;
                out_b     <= sel_b;
                out_op    <= sel_op;
                out_id    <= win;
                // Advance past the winner even when it keeps the lock, so it
                // drops to lowest priority once it releases.
                rr_ptr    <= win + 1'b1;
                unique case (lock_state)
                    UNLOCKED: begin
                        if (req_lock[win]) begin
                            lock_state <= LOCKED;
                            lock_owner <= win;
                        end
                    end
                    LOCKED: begin
                        if (!req_lock[win]) begin
                            lock_state <= UNLOCKED;
                        end
                    end
                    default: lock_state <= UNLOCKED;
                endcase
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_req_arbiter
// Directed bench for alu_req_arbiter. A small reference model predicts the
// winner, ready strobe and lock state each cycle; predicted issue-register
// contents are queued at transfer time and compared while they are held and
// when the ALU accepts them.
// -----------------------------------------------------------------------------
module tb_alu_req_arbiter;

    localparam int WIDTH = 32;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int OP_W  = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_lock;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ*OP_W-1:0]  req_op;
    logic [N_REQ-1:0]       req_ready;
    logic [ID_W-1:0]        grant_sel;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_a;
    logic [WIDTH-1:0]       out_b;
    logic [OP_W-1:0]        out_op;
    logic [ID_W-1:0]        out_id;
    logic                   locked;

    alu_req_arbiter #(
        .WIDTH (WIDTH),
        .N_REQ (N_REQ),
        .ID_W  (ID_W),
        .OP_W  (OP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_ready (req_ready),
        .grant_sel (grant_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_op    (out_op),
        .out_id    (out_id),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OP_W-1:0]  op;
    } exp_t;

    exp_t sb[$];

    logic [WIDTH-1:0] a_v  [N_REQ];
    logic [WIDTH-1:0] b_v  [N_REQ];
    logic [OP_W-1:0]  op_v [N_REQ];

    // Reference model state
    int              m_ptr;
    bit              m_locked;
    int              m_owner;
    bit              m_ov;
    logic [ID_W-1:0] m_last;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_locked = 0;
        m_owner  = 0;
        m_ov     = 0;
        m_last   = '0;
        sb.delete();
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N_REQ; i++) begin
            a_v[i]  = $urandom;
            b_v[i]  = $urandom;
            op_v[i] = OP_W'($urandom_range(0, 15));
        end
    endtask

    // One clock cycle: drive packed buses, check combinational outputs and the
    // held operation at the falling edge, then advance the model at the edge.
    task automatic step(input string name);
        int   w;
        bit   has;
        bit   can_load;
        logic [N_REQ-1:0] exp_rdy;
        exp_t e;

        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = a_v[i];
            req_b[i*WIDTH +: WIDTH] = b_v[i];
            req_op[i*OP_W +: OP_W]  = op_v[i];
        end
        @(negedge clk);

        has = 0;
        w   = 0;
        if (m_locked) begin
            w   = m_owner;
            has = req_valid[w];
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                int idx;
                idx = (m_ptr + k) % N_REQ;
                if (!has && req_valid[idx]) begin
                    has = 1;
                    w   = idx;
                end
            end
        end
        can_load = !m_ov || out_ready;
        exp_rdy  = (can_load && has) ? N_REQ'(1 << w) : '0;

        check({name, " req_ready"}, 64'(req_ready), 64'(exp_rdy));
        check({name, " grant_sel"}, 64'(grant_sel), has ? 64'(w) : 64'(m_last));
        check({name, " out_valid"}, 64'(out_valid), 64'(m_ov));
        check({name, " locked"},    64'(locked),    64'(m_locked));

        if (m_ov) begin
            if (sb.size() == 0) begin
                check({name, " scoreboard underflow"}, 64'(sb.size()), 64'd1);
            end else begin
                e = sb[0];
                check({name, " out_id"}, 64'(out_id), 64'(e.id));
                check({name, " out_a"},  64'(out_a),  64'(e.a));
                check({name, " out_b"},  64'(out_b),  64'(e.b));
                check({name, " out_op"}, 64'(out_op), 64'(e.op));
                if (out_ready) void'(sb.pop_front());
            end
        end
        if (can_load && has) begin
            e.id = ID_W'(w);
            e.a  = a_v[w];
            e.b  = b_v[w];
            e.op = op_v[w];
            sb.push_back(e);
        end

        @(posedge clk);
        #1;
        if (can_load && has) begin
            m_ov     = 1;
            m_ptr    = (w + 1) % N_REQ;
            m_locked = req_lock[w];
            m_owner  = w;
        end else if (out_ready) begin
            m_ov = 0;
        end
        if (has) m_last = ID_W'(w);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_lock  = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            a_v[i]  = '0;
            b_v[i]  = '0;
            op_v[i] = '0;
        end
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_a",     64'(out_a),     64'd0);
        check("reset out_b",     64'(out_b),     64'd0);
        check("reset out_op",    64'(out_op),    64'd0);
        check("reset out_id",    64'(out_id),    64'd0);
        check("reset locked",    64'(locked),    64'd0);
        check("reset req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;

        // Single request from requester 2
        a_v[2] = 32'h0000_0005; b_v[2] = 32'h0000_0003; op_v[2] = 4'h1;
        req_valid = 4'b0100; out_ready = 1'b1;
        step("single");
        req_valid = 4'b0000;
        step("single_out");
        check("single out_id direct", 64'(out_id), 64'd2);

        // Round robin, all four valid, ALU always ready
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            rand_payload();
            step("rr");
        end
        req_valid = 4'b0000;
        step("rr_drain");
        step("rr_idle");

        // Backpressure with requesters 1 and 3
        rand_payload();
        req_valid = 4'b1010; out_ready = 1'b1;
        step("bp_load");
        out_ready = 1'b0;
        repeat (3) step("bp_hold");
        out_ready = 1'b1;
        step("bp_release");
        step("bp_next");
        req_valid = 4'b0000;
        step("bp_drain");
        step("bp_idle");

        // Lock sequence owned by requester 1
        rand_payload();
        req_valid = 4'b0010; req_lock = 4'b0010;
        step("lock_take");
        req_valid = 4'b0101; req_lock = 4'b0000;
        step("lock_gap0");
        step("lock_gap1");
        check("lock held in gap", 64'(locked), 64'd1);
        req_valid = 4'b0111;
        step("lock_release");
        req_valid = 4'b0101;
        step("after_unlock");
        check("after unlock out_id", 64'(out_id), 64'd2);
        req_valid = 4'b0000;
        step("lock_drain");
        step("lock_idle");

        // Reset mid-operation while locked and holding an operation
        rand_payload();
        req_valid = 4'b1000; req_lock = 4'b1000; out_ready = 1'b0;
        step("pre_reset");
        check("pre_reset locked", 64'(locked), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset locked",    64'(locked),    64'd0);
        check("midreset out_id",    64'(out_id),    64'd0);
        model_reset();
        req_lock  = 4'b0000;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rand_payload();
        step("post_reset");
        check("post_reset winner", 64'(out_id), 64'd0);
        req_valid = 4'b0000;
        step("post_drain");
        step("post_idle");
        check("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
